// File: rtl/histogram_calculator_pkg.sv
// Shared widths, state encoding and the saturating increment used by the
// histogram calculator.
package histogram_calculator_pkg;

  localparam int PIXEL_W  = 8;
  localparam int COUNT_W  = 16;
  localparam int NUM_BINS = 2 ** PIXEL_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ARMED = 3'd2,
    COUNT = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Bins stick at all-ones instead of wrapping back to zero.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/histogram_calculator_if.sv
// Pixel stream, control events and bin read port of the histogram calculator.
interface histogram_calculator_if;
  import histogram_calculator_pkg::*;

  // in_valid qualifies in_pixel on every rising edge; there is no ready/back-pressure,
  // the block accepts one pixel per clock whenever in_valid=1.
  logic [PIXEL_W-1:0] in_pixel;
  logic               in_valid;
  logic               calc_flag;
  logic               end_of_frame;
  logic [PIXEL_W-1:0] external_addr_rd;
  logic [COUNT_W-1:0] external_data_rd;
  logic               out_valid;

  modport master (
    output in_pixel, in_valid, calc_flag, end_of_frame, external_addr_rd,
    input  external_data_rd, out_valid
  );

  modport slave (
    input  in_pixel, in_valid, calc_flag, end_of_frame, external_addr_rd,
    output external_data_rd, out_valid
  );

endinterface

// File: rtl/histogram_calculator_ram.sv
// Bin storage: one write port and an internal read port for clear/increment,
// plus an independent registered read port for external readers.
module histogram_ram
  import histogram_calculator_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [PIXEL_W-1:0] wr_addr,
  input  logic [COUNT_W-1:0] wr_data,
  input  logic [PIXEL_W-1:0] rd_addr,
  output logic [COUNT_W-1:0] rd_data,
  input  logic [PIXEL_W-1:0] ext_addr,
  output logic [COUNT_W-1:0] ext_data
);

  logic [COUNT_W-1:0] mem [NUM_BINS];

  // Internal read returns the pre-write value on an address collision;
  // the increment pipeline forwards around that.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) ext_data <= '0;
    else     ext_data <= mem[ext_addr];
  end

endmodule

// File: rtl/histogram_calculator.sv
// Frame histogram of luma pixels: request/clear/arm/count/drain FSM with a
// two-stage read-modify-write increment pipeline into a 256-bin memory.
module histogram_calculator
  import histogram_calculator_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  histogram_calculator_if.slave        bus,
  output state_t                       dbg_state
);

  state_t state, state_nxt;

  logic cf_q, eof_q, cf_evt, eof_evt;
  logic [PIXEL_W-1:0] clr_addr;
  logic drain_cnt;
  logic clear_we, count_en, out_valid_c;

  logic               s1_valid;
  logic [PIXEL_W-1:0] s1_addr;
  logic               wb_valid;
  logic [PIXEL_W-1:0] wb_addr;
  logic [COUNT_W-1:0] wb_data;
  logic [COUNT_W-1:0] ram_rd_data, operand, inc_data;

  logic               ram_we;
  logic [PIXEL_W-1:0] ram_wr_addr;
  logic [COUNT_W-1:0] ram_wr_data;
  logic [COUNT_W-1:0] ext_data;

  assign cf_evt  = bus.calc_flag & ~cf_q;
  assign eof_evt = bus.end_of_frame & ~eof_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cf_q  <= 1'b0;
      eof_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cf_q  <= bus.calc_flag;
      eof_q <= bus.end_of_frame;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cf_evt) state_nxt = CLEAR;
      CLEAR:   if (clr_addr == PIXEL_W'(NUM_BINS - 1)) state_nxt = ARMED;
      ARMED:   if (eof_evt) state_nxt = COUNT;
      COUNT:   if (eof_evt) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = DONE;
      DONE:    if (cf_evt) state_nxt = CLEAR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clear_we    = 1'b0;
    count_en    = 1'b0;
    out_valid_c = 1'b0;
    unique case (state)
      CLEAR:   clear_we    = 1'b1;
      COUNT:   count_en    = bus.in_valid;
      DONE:    out_valid_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr  <= '0;
      drain_cnt <= 1'b0;
    end else begin
      clr_addr  <= (state == CLEAR) ? clr_addr + PIXEL_W'(1) : '0;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // Stage 1 holds the pixel whose bin read is returning; its write lands at the
  // same edge the next pixel's read is sampled, so that read sees stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      s1_valid <= count_en;
      s1_addr  <= bus.in_pixel;
      wb_valid <= s1_valid;
      wb_addr  <= s1_addr;
      wb_data  <= inc_data;
    end
  end

  assign operand  = (wb_valid && (wb_addr == s1_addr)) ? wb_data : ram_rd_data;
  assign inc_data = sat_inc(operand);

  assign ram_we      = clear_we | s1_valid;
  assign ram_wr_addr = clear_we ? clr_addr : s1_addr;
  assign ram_wr_data = clear_we ? '0 : inc_data;

  histogram_ram u_ram (
    .clk      (clk),
    .rst      (rst),
    .we       (ram_we),
    .wr_addr  (ram_wr_addr),
    .wr_data  (ram_wr_data),
    .rd_addr  (bus.in_pixel),
    .rd_data  (ram_rd_data),
    .ext_addr (bus.external_addr_rd),
    .ext_data (ext_data)
  );

  assign bus.external_data_rd = ext_data;
  assign bus.out_valid        = out_valid_c;
  assign dbg_state            = state;

endmodule

// File: tb/tb_histogram_calculator.sv
// Directed bench for histogram_calculator: nominal frame, forwarding, saturation,
// ignored/re-armed requests and reset during counting.
module tb_histogram_calculator;
  import histogram_calculator_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  histogram_calculator_if bus ();

  histogram_calculator dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [COUNT_W-1:0] exp_q[$];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sweeps bins lo..hi through the registered read port, one address per cycle.
  task automatic read_check(input string tag, input int lo, input int hi, input logic [COUNT_W-1:0] exp);
    logic [COUNT_W-1:0] e;
    for (int a = lo; a <= hi + 1; a++) begin
      @(negedge clk);
      if (a > lo) begin
        e = exp_q.pop_front();
        vectors++;
        assert (bus.external_data_rd === e) else begin
          miscompares++;
          $error("FAIL %s bin=%0h observed=%0h expected=%0h", tag, a - 1, bus.external_data_rd, e);
        end
      end
      if (a <= hi) begin
        bus.external_addr_rd = PIXEL_W'(a);
        exp_q.push_back(exp);
      end
    end
  endtask

  task automatic request(input int hold);
    bus.calc_flag = 1'b1;
    tick(hold);
    bus.calc_flag = 1'b0;
  endtask

  task automatic wait_state(input string tag, input state_t s, input int budget);
    int n = 0;
    while (dbg_state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(dbg_state), 32'(s));
  endtask

  task automatic eof_pulse();
    bus.end_of_frame = 1'b1;
    tick(2);
    bus.end_of_frame = 1'b0;
    tick(1);
  endtask

  // Closing end_of_frame edge, optionally with a final pixel in the same cycle.
  task automatic close_frame(input string tag, input bit with_px, input logic [PIXEL_W-1:0] px);
    int n = 0;
    bus.end_of_frame = 1'b1;
    bus.in_valid     = with_px;
    bus.in_pixel     = px;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      n++;
    end while (bus.out_valid !== 1'b1 && n < 3);
    bus.end_of_frame = 1'b0;
    check_val(tag, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic drive_const(input logic [PIXEL_W-1:0] v, input int n);
    bus.in_valid = 1'b1;
    bus.in_pixel = v;
    tick(n);
    bus.in_valid = 1'b0;
  endtask

  // 5 blank lines, then 10 lines of 16 pixels {row,col} with a short hblank.
  task automatic drive_nominal(input bit poke_calc);
    tick(5 * 20);
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 16; c++) begin
        bus.in_valid  = 1'b1;
        bus.in_pixel  = {r[3:0], c[3:0]};
        bus.calc_flag = poke_calc && (r == 4) && (c == 8);
        tick(1);
      end
      bus.in_valid  = 1'b0;
      bus.calc_flag = 1'b0;
      tick(4);
    end
  endtask

  task automatic arm();
    request(1);
    wait_state("armed", ARMED, 300);
    eof_pulse();
  endtask

  initial begin
    rst                  = 1'b1;
    bus.in_pixel         = '0;
    bus.in_valid         = 1'b0;
    bus.calc_flag        = 1'b0;
    bus.end_of_frame     = 1'b0;
    bus.external_addr_rd = '0;
    tick(3);
    check_val("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("reset_data", 32'(bus.external_data_rd), 32'd0);
    check_val("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    tick(1);

    // Nominal frame
    eof_pulse();
    check_val("eof_in_idle", 32'(dbg_state), 32'(IDLE));
    request(6);
    tick(250);
    check_val("clear_cycle_256", 32'(dbg_state), 32'(CLEAR));
    check_val("clear_out_valid", 32'(bus.out_valid), 32'd0);
    tick(1);
    check_val("clear_to_armed", 32'(dbg_state), 32'(ARMED));
    drive_const(8'h33, 10);
    eof_pulse();
    check_val("armed_to_count", 32'(dbg_state), 32'(COUNT));
    drive_nominal(1'b0);
    close_frame("nominal_done", 1'b0, '0);
    read_check("nominal_low", 8'h00, 8'h9f, 16'd1);
    read_check("nominal_high", 8'ha0, 8'hff, 16'd0);

    // Re-arm from DONE: old counts must be cleared
    bus.calc_flag = 1'b1;
    tick(1);
    bus.calc_flag = 1'b0;
    check_val("rearm_drop", 32'(bus.out_valid), 32'd0);
    wait_state("rearm_armed", ARMED, 300);
    eof_pulse();
    drive_const(8'h00, 160);
    close_frame("rearm_done", 1'b0, '0);
    read_check("rearm_bin0", 8'h00, 8'h00, 16'd160);
    read_check("rearm_rest", 8'h01, 8'hff, 16'd0);

    // Identical pixels, last one coincident with end_of_frame
    arm();
    drive_const(8'h55, 199);
    close_frame("ident_done", 1'b1, 8'h55);
    read_check("ident_below", 8'h00, 8'h54, 16'd0);
    read_check("ident_bin", 8'h55, 8'h55, 16'd200);
    read_check("ident_above", 8'h56, 8'hff, 16'd0);

    // calc_flag during COUNT is ignored
    arm();
    drive_nominal(1'b1);
    check_val("calc_in_count", 32'(dbg_state), 32'(COUNT));
    close_frame("ignored_done", 1'b0, '0);
    read_check("ignored_low", 8'h00, 8'h9f, 16'd1);
    read_check("ignored_high", 8'ha0, 8'hff, 16'd0);

    // Saturation
    arm();
    drive_const(8'h10, 70000);
    drive_const(8'h11, 3);
    close_frame("sat_done", 1'b0, '0);
    read_check("sat_bin0f", 8'h0f, 8'h0f, 16'd0);
    read_check("sat_bin10", 8'h10, 8'h10, 16'hffff);
    read_check("sat_bin11", 8'h11, 8'h11, 16'd3);

    // Reset mid-COUNT
    arm();
    bus.external_addr_rd = 8'h20;
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'h20;
    tick(50);
    rst = 1'b1;
    tick(1);
    check_val("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("midrst_data", 32'(bus.external_data_rd), 32'd0);
    check_val("midrst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    bus.in_valid = 1'b0;
    eof_pulse();
    eof_pulse();
    tick(5);
    check_val("midrst_no_valid", 32'(bus.out_valid), 32'd0);
    check_val("midrst_idle", 32'(dbg_state), 32'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
